// File: rtl/bnn_pkg.sv
// Shared BNN types and constants.
// Used by the BPU group and its post-processing stages.
package bnn_pkg;

  localparam int CH   = 8;
  localparam int SW   = 7;
  localparam int POOL = 4;

  typedef logic signed [SW-1:0] sum_t;
  typedef sum_t [CH-1:0] sum_vec_t;

endpackage

// File: rtl/bpu_out_fifo.sv
// Small synchronous FIFO with occupancy count.
// Head word is presented combinationally on dout.
module bpu_out_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_wr;
  logic [AW-1:0]           r_rd;
  logic [AW:0]             r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + 1'b1;
      end
      if (pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (push && !pop) begin
        r_count <= r_count + 1'b1;
      end else if (pop && !push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign dout  = r_mem[r_rd];
  assign count = r_count;
  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);

endmodule

// File: rtl/bpu_act_pool.sv
// Binarize BPU lane sums against per-channel thresholds,
// OR-pool over POOL samples and queue packed bytes.
module bpu_act_pool #(
  parameter int CH    = bnn_pkg::CH,
  parameter int SW    = bnn_pkg::SW,
  parameter int POOL  = bnn_pkg::POOL,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SW-1:0]          thr_in,
  input  logic                   thr_en,
  input  logic [CH-1:0][SW-1:0]  sum_in,
  input  logic                   sum_valid,
  output logic                   sum_ready,
  input  logic                   pool_bypass,
  output logic [CH-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(POOL);
  localparam logic [CW-1:0] LAST     = CW'(POOL-1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [CH-1:0][SW-1:0] r_thr;
  logic [CH-1:0]         r_acc;
  logic [CW-1:0]         r_cnt;

  logic [CH-1:0] w_act;
  logic [CH-1:0] w_din;
  logic          w_accept;
  logic          w_emit;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;

  always_comb begin
    w_act = '0;
    for (int c = 0; c < CH; c++) begin
      w_act[c] = $signed(sum_in[c]) >= $signed(r_thr[c]);
    end
  end

  // Ready looks only at the registered count: no out_ready path.
  assign sum_ready = rst & (w_count < FULL_CNT);
  assign w_accept  = sum_valid & sum_ready;
  assign w_emit    = pool_bypass | (r_cnt == LAST);
  assign w_push    = w_accept & w_emit & ~w_full;
  assign w_din     = pool_bypass ? w_act : (r_acc | w_act);
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_thr <= '0;
    end else if (thr_en) begin
      r_thr <= {r_thr[CH-2:0], thr_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_emit) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= r_acc | w_act;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  bpu_out_fifo #(
    .W     (CH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (out_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

endmodule

// File: tb/tb_bpu_act_pool.sv
// Randomized and directed bench for bpu_act_pool
// against a queue-based behavioural model.
module tb_bpu_act_pool;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [6:0]      thr_in = '0;
  logic            thr_en = 1'b0;
  logic [7:0][6:0] sum_in = '0;
  logic            sum_valid = 1'b0;
  logic            sum_ready;
  logic            pool_bypass = 1'b0;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;

  bpu_act_pool dut (
    .clk         (clk),
    .rst         (rst),
    .thr_in      (thr_in),
    .thr_en      (thr_en),
    .sum_in      (sum_in),
    .sum_valid   (sum_valid),
    .sum_ready   (sum_ready),
    .pool_bypass (pool_bypass),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int         s[8];
  int         hist[$];
  logic [7:0] q[$];
  logic [7:0] win[$];
  logic [7:0] dut_pops[$];
  bit         last_acc;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_act();
    logic [7:0] a;
    int t;
    a = '0;
    for (int c = 0; c < 8; c++) begin
      t = (c < hist.size()) ? hist[hist.size()-1-c] : 0;
      a[c] = (s[c] >= t);
    end
    return a;
  endfunction

  task automatic cycle();
    logic [7:0] a;
    logic [7:0] o;
    bit exp_rdy;
    bit exp_vld;
    bit acc;
    for (int c = 0; c < 8; c++) sum_in[c] = s[c][6:0];
    #2;
    if (!rst) begin
      q.delete();
      win.delete();
      hist.delete();
      check("rst_ready", {31'd0, sum_ready}, 0);
      check("rst_valid", {31'd0, out_valid}, 0);
      check("rst_data", {24'd0, out_data}, 0);
      last_acc = 0;
    end else begin
      exp_rdy = (q.size() < 4);
      exp_vld = (q.size() > 0);
      check("ready", {31'd0, sum_ready}, {31'd0, exp_rdy});
      check("valid", {31'd0, out_valid}, {31'd0, exp_vld});
      if (exp_vld) check("data", {24'd0, out_data}, {24'd0, q[0]});
      if (out_valid && out_ready) dut_pops.push_back(out_data);
      acc = sum_valid && exp_rdy;
      a = model_act();
      if (exp_vld && out_ready) void'(q.pop_front());
      if (acc) begin
        if (pool_bypass) begin
          q.push_back(a);
          win.delete();
        end else begin
          win.push_back(a);
          if (win.size() == 4) begin
            o = '0;
            foreach (win[i]) o |= win[i];
            q.push_back(o);
            win.delete();
          end
        end
      end
      if (thr_en) hist.push_back(int'($signed(thr_in)));
      last_acc = acc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_thr(int w);
    thr_en = 1'b1;
    thr_in = w[6:0];
    cycle();
    thr_en = 1'b0;
  endtask

  task automatic load_all(int w);
    for (int i = 0; i < 8; i++) load_thr(w);
  endtask

  task automatic set_byte(logic [7:0] b);
    for (int c = 0; c < 8; c++) s[c] = b[c] ? 1 : -1;
  endtask

  task automatic send(bit byp);
    sum_valid = 1'b1;
    pool_bypass = byp;
    last_acc = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) check("send_timeout", 0, 1);
    sum_valid = 1'b0;
  endtask

  task automatic idle(int n);
    sum_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    if (q.size() != 0) check("drain_timeout", 0, 1);
    cycle();
    out_ready = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 8; c++) s[c] = 0;
    idle(2);
    #1 rst = 1'b1;
    idle(2);

    // thresholds: channel c gets c
    for (int w = 7; w >= 0; w--) load_thr(w);
    for (int c = 0; c < 8; c++) s[c] = 3;
    send(1'b1);
    #1 check("thr_cmp", {24'd0, out_data}, 32'h0F);
    for (int c = 0; c < 8; c++) s[c] = c - 1;
    send(1'b1);
    drain();
    check("thr_below", {24'd0, dut_pops[dut_pops.size()-1]}, 32'h00);

    // signed extremes
    load_all(-64);
    for (int c = 0; c < 8; c++) s[c] = -64;
    send(1'b1);
    #1 check("min_eq", {24'd0, out_data}, 32'hFF);
    drain();
    load_all(63);
    for (int c = 0; c < 8; c++) s[c] = 62;
    send(1'b1);
    #1 check("max_below", {24'd0, out_data}, 32'h00);
    drain();

    // pooling with gaps
    load_all(0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) s[c] = (c == k) ? 5 : -1;
      send(1'b0);
      if (k == 1) idle(2);
      if (k < 3) check("pool_early", {31'd0, out_valid}, 0);
    end
    #1 check("pool_valid", {31'd0, out_valid}, 1);
    check("pool_byte", {24'd0, out_data}, 32'h0F);
    idle(2);
    drain();

    // backpressure
    dut_pops.delete();
    for (int v = 1; v <= 4; v++) begin
      set_byte(8'(v));
      send(1'b1);
    end
    #1 check("bp_full", {31'd0, sum_ready}, 0);
    set_byte(8'd5);
    sum_valid = 1'b1;
    pool_bypass = 1'b1;
    cycle();
    check("bp_stall", {31'd0, last_acc}, 0);
    out_ready = 1'b1;
    send(1'b1);
    set_byte(8'd6);
    send(1'b1);
    drain();
    check("bp_count", dut_pops.size(), 6);
    for (int i = 0; i < 6 && i < dut_pops.size(); i++)
      check("bp_order", {24'd0, dut_pops[i]}, i + 1);

    // bypass discards partial window
    dut_pops.delete();
    set_byte(8'hF0);
    send(1'b0);
    send(1'b0);
    set_byte(8'h01);
    send(1'b1);
    for (int k = 0; k < 4; k++) begin
      set_byte(8'(1 << (k + 2)));
      send(1'b0);
    end
    drain();
    check("byp_count", dut_pops.size(), 2);
    if (dut_pops.size() == 2) begin
      check("byp_first", {24'd0, dut_pops[0]}, 32'h01);
      check("byp_pool", {24'd0, dut_pops[1]}, 32'h3C);
    end

    // reset mid-operation
    set_byte(8'h11);
    send(1'b1);
    set_byte(8'h22);
    send(1'b1);
    set_byte(8'h80);
    send(1'b0);
    send(1'b0);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(1);
    check("rst_empty", {31'd0, out_valid}, 0);
    dut_pops.delete();
    for (int c = 0; c < 8; c++) s[c] = 0;
    for (int k = 0; k < 4; k++) send(1'b0);
    drain();
    check("rst_count", dut_pops.size(), 1);
    if (dut_pops.size() == 1) check("rst_byte", {24'd0, dut_pops[0]}, 32'hFF);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      thr_en = ($urandom % 4) == 0;
      thr_in = 7'($urandom);
      for (int c = 0; c < 8; c++) s[c] = int'($urandom_range(0, 127)) - 64;
      sum_valid = ($urandom % 4) != 0;
      pool_bypass = ($urandom % 8) == 0;
      out_ready = ($urandom % 3) != 0;
      rst = ($urandom % 200) != 0;
      cycle();
    end
    rst = 1'b1;
    thr_en = 1'b0;
    sum_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bpu_act_pool.md
# bpu_act_pool

Post-processing stage directly downstream of the 8-lane BPU group. It takes the eight signed 7-bit popcount sums per step and binarizes each lane against a per-channel threshold. It then max-pools the binary activations over windows of 4 samples (a 2x2 window, which reduces to OR), and packs one bit per channel into a byte. The byte is delivered through a small output FIFO with a valid/ready handshake toward the output buffer.

## Interface
Parameters:
- CH, 8, channel (lane) count; one output bit per channel
- SW, 7, signed sum / threshold width
- POOL, 4, samples per pooling window
- DEPTH, 4, output FIFO entries (power of 2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- thr_in  in  SW  signed threshold word
- thr_en  in  1  shift thr_in into threshold chain
- sum_in  in  CH x SW  signed popcount sums; lane c = sum_in[c]
- sum_valid  in  1  sum_in valid this cycle
- sum_ready  out  1  stage can accept a sample
- pool_bypass  in  1  1: each accepted sample is emitted unpooled
- out_data  out  CH  packed activations; bit c = channel c
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer takes out_data

## Operation
- Threshold chain: on thr_en, thr <= {thr[CH-2:0], thr_in}. After CH loads, the first word loaded sits in channel CH-1 and the last in channel 0. It is independent of sum traffic and may be loaded on any cycle.
- Accept: accept = sum_valid & sum_ready. sum_ready = (fifo_count < DEPTH) while rst is high, and 0 while rst is low.
- Binarize: act[c] = ($signed(sum_in[c]) >= $signed(thr[c])). Both operands are SW-bit signed, so there is no extension and no overflow. Equality gives 1.
- Pool (pool_bypass=0): acc and cnt (0..POOL-1).
  - Accept with cnt<POOL-1: acc |= act, cnt++.
  - Accept with cnt==POOL-1: push (acc|act), then acc=0, cnt=0.
- Bypass (pool_bypass=1, sampled at accept): push act and clear acc/cnt. Any partial window is discarded.
- No state machine beyond cnt. The pool is in state IDLE when cnt==0 and ACCUM otherwise.
- FIFO: push and pop are allowed in the same cycle.
  - The pop condition is out_valid & out_ready.
  - A push never occurs while full, because sum_ready gates it.
  - Ordering is strict FIFO. Pointers wrap modulo DEPTH.
- thr_en simultaneous with an accept: the compare uses the pre-shift thresholds.

## Timing
- Reset values:
  - thr = 0, acc = 0, cnt = 0, FIFO empty
  - out_valid = 0, out_data = 0, sum_ready = 0 while asserted
- Reset mid-window or with a non-empty FIFO: all of the above state is lost. No partial output.
- Latency: an accept at edge N that pushes makes out_valid = 1 and shows the byte on out_data after edge N (combinational from the FIFO head).
- Full FIFO:
  - sum_ready = 0 in that cycle, even if a pop is occurring. ready is derived from the registered count only, so there is no out_ready -> sum_ready combinational path.
  - sum_ready rises the cycle after the pop.
- Empty FIFO: out_valid = 0 and out_data holds the last head value. Do not care; the bench must not check it.
- A pooled byte needs exactly POOL accepts. Gaps with sum_valid = 0 are allowed between accepts.
- Throughput: one sample per cycle while not full. Sustained one byte per cycle in bypass when out_ready = 1.

## Structure
- Shared package bnn_pkg holds:
  - constants CH, SW, POOL
  - typedef logic signed [SW-1:0] sum_t
  - typedef sum_t [CH-1:0] sum_vec_t, which is also used by the BPU group output
- Sub-module bpu_out_fifo: parameterized CH-wide synchronous FIFO with count, async active-low reset, and push/pop/full/empty outputs.
- Binarize and pool logic stay in bpu_act_pool.

## Test plan
- Threshold load and compare:
  - Stimulus: shift in 8 words 7,6,5,4,3,2,1,0 (channel c gets c). Bypass with every lane sum=3.
  - Required: out_data = 0x0F.
  - Then with sum = thr - 1 per lane: out_data = 0x00.
- Signed edges:
  - Stimulus: thr all -64, sums all -64.
  - Required: 0xFF.
  - Stimulus: thr all 63, sums all 62.
  - Required: 0x00. There must be no wrap errors.
- Pooling:
  - Setup: thr = 0. Four accepts where sample k has lane k = 5 and all others = -1. Insert 2 idle cycles between samples 2 and 3.
  - Required: exactly one byte, 0x0F, visible after the 4th accept edge.
- Backpressure:
  - Setup: out_ready = 0, bypass, drive 6 valid samples with values 0x01..0x06.
  - Required: sum_ready drops after 4 accepts.
  - Then set out_ready = 1. Required: bytes pop in order 0x01..0x06, and sum_ready re-rises one cycle after the first pop.
- Bypass mid-window:
  - Stimulus: 2 pooled accepts producing 0xF0, then 1 bypass accept producing 0x01.
  - Required: single output 0x01.
  - A following 4-sample pool emits only its own OR.
- Reset mid-operation:
  - Setup: 2 pooled accepts plus 2 bytes queued, then rst low for 1 cycle.
  - Required: out_valid = 0 and sum_ready = 0 during reset, FIFO empty after.
  - The next 4 accepts with all sums = thr yield only 0xFF.
